// File: rtl/core101_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core101_pkg
//  Description : Shared constants and loader state encoding for the Core101
//                instruction-memory responder.
//  Revision    : 1.0
// ============================================================================
package core101_pkg;

    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    localparam int unsigned C_STATE_W = 2;
    localparam logic [C_STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [C_STATE_W-1:0] ST_LOAD = 2'd1;
    localparam logic [C_STATE_W-1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_byte_packer
//  Description : Assembles little-endian bytes into 32-bit words and strobes
//                word_valid in the same cycle the fourth byte is accepted.
//  Revision    : 1.0
// ============================================================================
module imem_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;
    logic        w_accept;

    assign w_accept     = i_enable & i_byte_valid;
    // Byte 3 bypasses the register so the word is complete at the 4th edge.
    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = w_accept & (r_byte_cnt == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
        end else if (i_clear) begin
            r_byte_cnt <= 2'd0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
                2'd0:    r_shift[7:0]   <= i_byte;
                2'd1:    r_shift[15:8]  <= i_byte;
                2'd2:    r_shift[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder
//  Description : Zero-latency instruction memory for the Core101 fetch port
//                with a byte-serial program loader that holds the core.
//  Revision    : 1.0
// ============================================================================
module imem_responder
    import core101_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_INSTR  = C_NOP_INSTR
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [31:0]           ins_mem_addr_in,
    output logic [31:0]           ins_mem_data_out,
    output logic                  addr_fault_out,
    input  logic                  load_start_in,
    input  logic [ADDR_WIDTH:0]   load_count_in,
    input  logic                  load_byte_valid_in,
    input  logic [7:0]            load_byte_in,
    output logic                  load_byte_ready_out,
    output logic                  load_busy_out,
    output logic                  load_done_out,
    output logic                  load_error_out,
    output logic                  core_hold_out
);

    localparam int unsigned        C_DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_MAX_COUNT = (ADDR_WIDTH+1)'(C_DEPTH);

    logic [C_STATE_W-1:0]  r_state;
    logic [C_STATE_W-1:0]  w_state_nxt;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_word_addr;
    logic                  r_error;

    logic                  w_busy;
    logic                  w_count_bad;
    logic                  w_start_ok;
    logic                  w_start_bad;
    logic                  w_last_word;
    logic [31:0]           w_word;
    logic                  w_word_valid;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_fault;

    logic [31:0]           r_mem [0:C_DEPTH-1];

    imem_byte_packer u_packer (
        .clk          (clock_in),
        .rst          (reset_in),
        .i_enable     (w_busy),
        .i_clear      (w_start_ok),
        .i_byte_valid (load_byte_valid_in),
        .i_byte       (load_byte_in),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    assign w_busy      = (r_state == ST_LOAD);
    assign w_count_bad = (load_count_in == '0) || (load_count_in > C_MAX_COUNT);
    assign w_last_word = ({1'b0, r_word_addr} == (r_count - 1'b1));

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start_in) begin
                    if (w_count_bad) begin
                        w_start_bad = 1'b1;
                    end else begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                w_start_bad = load_start_in;
                if (w_word_valid && w_last_word) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_word_addr <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_bad) begin
                r_error <= 1'b1;
            end else if (w_start_ok) begin
                r_error <= 1'b0;
            end
            if (w_start_ok) begin
                r_count     <= load_count_in;
                r_word_addr <= '0;
            end else if (w_word_valid) begin
                // Natural wrap to 0 after the last word of a full-depth load.
                r_word_addr <= r_word_addr + 1'b1;
            end
        end
    end

    // Contents survive reset so an interrupted load keeps its written words.
    always_ff @(posedge clock_in) begin
        if (w_word_valid) begin
            r_mem[r_word_addr] <= w_word;
        end
    end

    assign w_index = ins_mem_addr_in[ADDR_WIDTH+1:2];
    assign w_fault = (|ins_mem_addr_in[1:0]) | (|ins_mem_addr_in[31:ADDR_WIDTH+2]);

    assign ins_mem_data_out    = (w_fault || w_busy) ? NOP_INSTR : r_mem[w_index];
    assign addr_fault_out      = w_fault;
    assign load_byte_ready_out = w_busy;
    assign load_busy_out       = w_busy;
    assign load_done_out       = (r_state == ST_DONE);
    assign load_error_out      = r_error;
    assign core_hold_out       = w_busy;

endmodule
`default_nettype wire
